// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file slice.
// XZR_IDX names the hard-wired zero register.
package regfile_pkg;

  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned DW_DEF    = 64;

  typedef logic [4:0]        reg_addr_t;
  typedef logic [DW_DEF-1:0] reg_data_t;

  localparam reg_addr_t XZR_IDX = 5'd31;

endpackage

// File: rtl/regfile_write_dec.sv
// One-hot write-enable decoder.
// The zero register and addresses at or above NREGS never get an enable.
module regfile_write_dec
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF
) (
  input  logic             en,
  input  reg_addr_t        waddr,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      onehot[i] = en && (32'(waddr) == i) && (i != 32'(XZR_IDX));
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hard-wired zero register and a
// committed-write counter. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RegWrite,
  input  reg_addr_t     WriteRegister,
  input  logic [DW-1:0] WriteData,
  input  reg_addr_t     ReadRegister1,
  input  reg_addr_t     ReadRegister2,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2,
  output logic [15:0]   wr_count
);

  logic [NREGS-1:0] wr_en;
  logic [DW-1:0]    regs_q [NREGS];
  logic [15:0]      wr_count_q, wr_count_d;
  logic             commit;

  regfile_write_dec #(
    .NREGS(NREGS)
  ) u_write_dec (
    .en    (RegWrite),
    .waddr (WriteRegister),
    .onehot(wr_en)
  );

  // A write commits only when the decoder raised an enable.
  assign commit = |wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= WriteData;
        end
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

`ifdef REGFILE_BYPASS_EN
  logic bypass_ok;
  // Gated by reset so outputs stay zero while reset is held.
  assign bypass_ok = reset_n && commit;
`endif

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (i != 32'(XZR_IDX)) begin
        if (32'(ReadRegister1) == i) begin
          ReadData1 = regs_q[i];
        end
        if (32'(ReadRegister2) == i) begin
          ReadData2 = regs_q[i];
        end
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (bypass_ok && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
    if (bypass_ok && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
`endif
  end

  wr_en_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(wr_en));
  wr_en_idle:   assert property (@(posedge clk) disable iff (!reset_n) !RegWrite |-> wr_en == '0);

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file (both REGFILE_BYPASS_EN builds).
module tb_register_file;
  import regfile_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        RegWrite;
  reg_addr_t   WriteRegister;
  logic [63:0] WriteData;
  reg_addr_t   ReadRegister1;
  reg_addr_t   ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [15:0] wr_count;

  int tests;
  int fails;

  typedef struct {
    logic        we;
    reg_addr_t   wa;
    logic [63:0] wd;
    reg_addr_t   ra1;
    reg_addr_t   ra2;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [6];

  register_file #(
    .NREGS(32),
    .DW   (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input reg_addr_t wa, input logic [63:0] wd);
    RegWrite      = 1'b1;
    WriteRegister = wa;
    WriteData     = wd;
    tick();
    RegWrite      = 1'b0;
  endtask

  initial begin
    logic [63:0] bypass_exp;
    tests = 0;
    fails = 0;
    reset_n       = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd5;
    tick();
    tick();
    check("reset_rd1", ReadData1, 64'h0);
    check("reset_rd2", ReadData2, 64'h0);
    check("reset_cnt", 64'(wr_count), 64'h0);
    reset_n = 1'b1;
    tick();

    // Basic write/read
    write(5'd5, 64'hDEADBEEF_00000001);
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    #1;
    check("basic_rd1", ReadData1, 64'hDEADBEEF_00000001);
    check("basic_rd2", ReadData2, 64'hDEADBEEF_00000001);
    check("basic_cnt", 64'(wr_count), 64'd1);

    // XZR
    write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    ReadRegister1 = 5'd31;
    #1;
    check("xzr_rd1", ReadData1, 64'h0);
    check("xzr_cnt", 64'(wr_count), 64'd1);

    // Same-cycle write/read of X7
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 64'h1234;
`else
    bypass_exp = 64'h0;
`endif
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'h1234;
    ReadRegister1 = 5'd7;
    #1;
    check("bypass_pre", ReadData1, bypass_exp);
    tick();
    RegWrite = 1'b0;
    #1;
    check("bypass_post", ReadData1, 64'h1234);
    check("bypass_cnt", 64'(wr_count), 64'd2);

    // Asynchronous reset mid-run, between clock edges
    ReadRegister2 = 5'd5;
    reset_n = 1'b0;
    #1;
    check("async_rst_rd1", ReadData1, 64'h0);
    check("async_rst_rd2", ReadData2, 64'h0);
    check("async_rst_cnt", 64'(wr_count), 64'h0);

    // Write held during reset must be lost
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 64'h55;
    ReadRegister1 = 5'd9;
    #1;
    check("rst_wr_bypass", ReadData1, 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("rst_wr_lost", ReadData1, 64'h0);
    check("rst_wr_cnt", 64'(wr_count), 64'h0);

    // Release reset and write on the very next edge
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      write(reg_addr_t'(i), 64'(i));
      if (i == 0) begin
        check("first_wr_cnt", 64'(wr_count), 64'd1);
      end
    end
    check("onehot_cnt", 64'(wr_count), 64'd31);
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = reg_addr_t'(i);
      ReadRegister2 = reg_addr_t'(30 - i);
      #1;
      check($sformatf("onehot_rd1_x%0d", i), ReadData1, 64'(i));
      check($sformatf("onehot_rd2_x%0d", 30 - i), ReadData2, 64'(30 - i));
    end

    vecs[0] = '{1'b1, 5'd3,  64'hA5A5, 5'd3,  5'd4,  64'hA5A5, 64'd4, 16'd32};
    vecs[1] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd3, 64'h0, 64'hA5A5, 16'd32};
    vecs[2] = '{1'b0, 5'd3,  64'hFFFF, 5'd3,  5'd3,  64'hA5A5, 64'hA5A5, 16'd32};
    vecs[3] = '{1'b1, 5'd30, 64'h8000_0000_0000_0000, 5'd30, 5'd31,
                64'h8000_0000_0000_0000, 64'h0, 16'd33};
    vecs[4] = '{1'b1, 5'd0,  64'h1, 5'd0,  5'd1,  64'h1, 64'h1, 16'd34};
    vecs[5] = '{1'b1, 5'd30, 64'hF, 5'd29, 5'd30, 64'd29, 64'hF, 16'd35};
    for (int v = 0; v < 6; v++) begin
      RegWrite      = vecs[v].we;
      WriteRegister = vecs[v].wa;
      WriteData     = vecs[v].wd;
      ReadRegister1 = vecs[v].ra1;
      ReadRegister2 = vecs[v].ra2;
      tick();
      RegWrite = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].e2);
      check($sformatf("vec%0d_cnt", v), 64'(wr_count), 64'(vecs[v].ecnt));
    end

    // Counter wrap
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd2;
    for (int i = 0; i < 65535; i++) begin
      WriteData = 64'(i);
      tick();
    end
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd2;
    #1;
    check("wrap_pre_cnt", 64'(wr_count), 64'hFFFF);
    check("wrap_pre_rd", ReadData1, 64'd65534);
    write(5'd2, 64'hBEEF);
    #1;
    check("wrap_cnt", 64'(wr_count), 64'h0);
    check("wrap_rd", ReadData1, 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
